// File: rtl/fifo_sync_if.sv
// Producer/consumer handshake bundle for fifo_sync: write port, read port and status.
interface fifo_sync_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 4
) ();
    logic              w_en;
    logic [WIDTH-1:0]  w_data;
    logic              r_en;
    logic [WIDTH-1:0]  r_data;
    logic              r_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output w_en, w_data, r_en,
        input  r_data, r_valid, count, full, empty,
        input  almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  w_en, w_data, r_en,
        output r_data, r_valid, count, full, empty,
        output almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO on a simple dual-port register array, one-cycle read latency,
// with occupancy count, threshold flags and registered overflow/underflow pulses.
module fifo_sync #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2
) (
    input logic         clk,
    input logic         rst,
    fifo_sync_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [CNT_W-1:0]  count_q;
    logic [WIDTH-1:0]  r_data_q;
    logic              r_valid_q;
    logic              overflow_q;
    logic              underflow_q;

    logic full_c;
    logic empty_c;
    logic rd_ok;
    logic wr_ok;

    // Status decodes of the registered occupancy.
    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign rd_ok = bus.r_en && !empty_c;
    assign wr_ok = bus.w_en && (!full_c || rd_ok);

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp] <= bus.w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp          <= '0;
            rp          <= '0;
            count_q     <= '0;
            r_data_q    <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            r_valid_q   <= rd_ok;
            overflow_q  <= bus.w_en && !wr_ok;
            underflow_q <= bus.r_en && !rd_ok;
            if (wr_ok) begin
                wp <= wp + ADDR_W'(1);
            end
            // At equal pointers (only when full) this reads the old word before the write lands.
            if (rd_ok) begin
                r_data_q <= mem[rp];
                rp       <= rp + ADDR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.r_data       = r_data_q;
    assign bus.r_valid      = r_valid_q;
    assign bus.count        = count_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: directed and randomized traffic checked against a queue-based model.
module tb_fifo_sync;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AF_LEVEL = 14;
    localparam int unsigned AE_LEVEL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_sync_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    fifo_sync #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: contents as an ordered queue plus the registered outputs.
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_rdata;
    logic             m_rvalid;
    logic             m_ovf;
    logic             m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = q.size();
        chk({ctx, ":count"},     32'(bus.count),        32'(n));
        chk({ctx, ":full"},      32'(bus.full),         32'(n == int'(DEPTH)));
        chk({ctx, ":empty"},     32'(bus.empty),        32'(n == 0));
        chk({ctx, ":afull"},     32'(bus.almost_full),  32'(n >= int'(AF_LEVEL)));
        chk({ctx, ":aempty"},    32'(bus.almost_empty), 32'(n <= int'(AE_LEVEL)));
        chk({ctx, ":r_valid"},   32'(bus.r_valid),      32'(m_rvalid));
        chk({ctx, ":r_data"},    32'(bus.r_data),       32'(m_rdata));
        chk({ctx, ":overflow"},  32'(bus.overflow),     32'(m_ovf));
        chk({ctx, ":underflow"}, 32'(bus.underflow),    32'(m_unf));
    endtask

    // Called just after a rising edge; applies inputs for one cycle and checks the result.
    task automatic step(input string ctx, input logic w, input logic [WIDTH-1:0] d, input logic r);
        logic rd;
        logic wr;
        bus.w_en   = w;
        bus.w_data = d;
        bus.r_en   = r;
        @(posedge clk);
        rd = r && (q.size() > 0);
        wr = w && ((q.size() < int'(DEPTH)) || rd);
        m_rvalid = rd;
        m_ovf    = w && !wr;
        m_unf    = r && !rd;
        if (rd) m_rdata = q.pop_front();
        if (wr) q.push_back(d);
        #1;
        check_all(ctx);
    endtask

    initial begin
        int idx;
        int n;
        int wp_bias;
        int rp_bias;
        bus.w_en   = 1'b0;
        bus.w_data = '0;
        bus.r_en   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Read while empty: underflow once, r_data stays 0.
        step("rd_empty", 1'b0, 8'h00, 1'b1);
        step("rd_empty_idle", 1'b0, 8'h00, 1'b0);

        // Three writes then three reads.
        step("w3a", 1'b1, 8'hA5, 1'b0);
        step("w3b", 1'b1, 8'h3C, 1'b0);
        step("w3c", 1'b1, 8'h0F, 1'b0);
        step("r3a", 1'b0, 8'h00, 1'b1);
        chk("r3a_lit", 32'(bus.r_data), 32'h0000_00A5);
        step("r3b", 1'b0, 8'h00, 1'b1);
        step("r3c", 1'b0, 8'h00, 1'b1);
        chk("r3c_lit", 32'(bus.r_data), 32'h0000_000F);
        step("r3_idle", 1'b0, 8'h00, 1'b0);

        // Fill to full, overflow, then simultaneous read+write at full.
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0);
        chk("fill_full_lit", 32'(bus.full), 32'd1);
        step("ovf", 1'b1, 8'hFF, 1'b0);
        chk("ovf_lit", 32'(bus.overflow), 32'd1);
        step("ovf_clear", 1'b0, 8'h00, 1'b0);
        step("rw_full", 1'b1, 8'h55, 1'b1);
        chk("rw_full_old", 32'(bus.r_data), 32'h0000_0000);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1);
        chk("drain_last", 32'(bus.r_data), 32'h0000_0055);
        step("drain_unf", 1'b0, 8'h00, 1'b1);

        // Wrap-around: 40 words in bursts of up to 3, each burst read back.
        idx = 0;
        while (idx < 40) begin
            n = (40 - idx < 3) ? (40 - idx) : 3;
            for (int k = 0; k < n; k++) step("wrap_w", 1'b1, 8'(idx + k), 1'b0);
            for (int k = 0; k < n; k++) step("wrap_r", 1'b0, 8'h00, 1'b1);
            idx += n;
        end

        // Randomized traffic with shifting bias so both full and empty are reached.
        for (int seg = 0; seg < 6; seg++) begin
            wp_bias = (seg % 2 == 0) ? 85 : 25;
            rp_bias = (seg % 2 == 0) ? 25 : 85;
            for (int c = 0; c < 60; c++) begin
                step("rand",
                     1'($urandom_range(0, 99) < wp_bias),
                     8'($urandom),
                     1'($urandom_range(0, 99) < rp_bias));
            end
        end
        while (q.size() > 0) step("rand_drain", 1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-burst with r_en held high.
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h10 + i), 1'b0);
        step("pre_rst_rd", 1'b0, 8'h00, 1'b1);
        bus.w_en = 1'b0;
        bus.r_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b0;
        bus.r_en = 1'b0;
        step("post_w", 1'b1, 8'h77, 1'b0);
        step("post_r", 1'b0, 8'h00, 1'b1);
        chk("post_r_lit", 32'(bus.r_data), 32'h0000_0077);
        step("post_idle", 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fifo_sync.md
# fifo_sync

Parametrised single-clock FIFO built on a simple dual-port memory with separate write and read ports. Write data is buffered in order and returned on the read port with one cycle of read latency. Occupancy count, full/empty flags, programmable almost-full/almost-empty flags and overflow/underflow error pulses are included. It sits between a producer and a consumer in the same clock domain, such as UART RX to a command parser or a sampler to an SPI streamer.

## Interface
- WIDTH, 8, data word width in bits
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W entries (default 16)
- AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- w_en  in  1  write request
- w_data  in  WIDTH  write word, sampled on the edge where the write is accepted
- r_en  in  1  read request
- r_data  out  WIDTH  read word, registered
- r_valid  out  1  one-cycle pulse: r_data was updated by an accepted read
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH x WIDTH register array. Contents are not reset.
- Write pointer wp and read pointer rp are each ADDR_W bits wide and wrap naturally from DEPTH-1 to 0.
- Read accept: rd_ok = r_en && !empty.
- Write accept: wr_ok = w_en && (!full || rd_ok). A write into a full FIFO succeeds when a read is accepted in the same cycle.
- On wr_ok: mem[wp] <= w_data; wp <= wp+1.
- On rd_ok: r_data <= mem[rp]; rp <= rp+1; r_valid <= 1. Otherwise r_data holds and r_valid <= 0.
- Count update:
  - wr_ok only: count+1
  - rd_ok only: count-1
  - both or neither: unchanged
- No fall-through. A read of an empty FIFO is rejected even when a write occurs in the same cycle.
- Simultaneous read and write at equal pointers can only happen when full. The read returns the old word at rp before it is overwritten.
- overflow <= w_en && !wr_ok; underflow <= r_en && !rd_ok. Both are registered, one-cycle pulses, and do not alter state.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count.
- Reset (any time, including mid-burst):
  - wp, rp, count = 0
  - r_data = 0
  - r_valid, overflow, underflow = 0
  - hence empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - Contents written before reset are unreachable afterwards.

## Timing
- Write accepted at edge N: count and flags reflect it after edge N. A read issued in the cycle after edge N is accepted at edge N+1.
- Read latency: r_en is sampled at edge N; r_data and r_valid are valid after edge N and held through the following cycle.
- Back-to-back reads sustain one word per cycle. r_valid stays high for consecutive accepted reads.
- Error pulses appear the cycle after the offending request, for exactly one cycle per rejected cycle.
- Reset is asynchronous: outputs go to reset values immediately on rst rising. Release is synchronous in effect; the first accepted operation occurs on the first rising edge with rst low.

## Test plan
- Reset, then read with FIFO empty -> empty=1, count=0, underflow pulses once, r_data stays 0x00, r_valid=0.
- Write 0xA5, 0x3C, 0x0F on 3 consecutive cycles, then 3 reads -> r_data = 0xA5, 0x3C, 0x0F on successive cycles with r_valid=1 each; count goes 3->0; empty=1 at the end.
- Write 16 words 0x00..0x0F:
  - almost_full rises after the 14th write; full=1 and count=16 after the 16th.
  - A 17th write (0xFF) -> overflow pulse, count stays 16.
  - Draining returns 0x00..0x0F in order.
- Full FIFO, assert w_en=1 (0x55) and r_en=1 together -> read returns the oldest word, write accepted, count stays 16, no overflow. The final drain returns 0x55 last.
- Wrap-around: 40 write/read pairs with data = index, spaced so count oscillates between 0 and 3 -> every r_data matches the written index. Pointers wrap twice with no corruption; almost_empty=1 whenever count<=2.
- Write 5 words, assert rst mid-cycle while r_en=1 -> immediately count=0, empty=1, r_valid=0, r_data=0. Afterwards, writing 0x77 and reading returns 0x77.
